// File: rtl/ysyx_23060191_trap_ctrl_pkg.sv
// Shared constants for the M-mode trap/return sequencer.
// This file holds the CSR addresses it touches, the mstatus bit positions
// and the 3-bit FSM state encodings.
package ysyx_23060191_trap_ctrl_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_T_EPC    = 3'd1;
    localparam logic [2:0] ST_T_CAUSE  = 3'd2;
    localparam logic [2:0] ST_T_STATUS = 3'd3;
    localparam logic [2:0] ST_T_VEC    = 3'd4;
    localparam logic [2:0] ST_R_STATUS = 3'd5;
    localparam logic [2:0] ST_R_EPC    = 3'd6;

endpackage

// File: rtl/ysyx_23060191_trap_ctrl.sv
// Trap/return sequencer for the M-mode CSR file.
// It owns the CSR file's single write port. In IDLE the port passes CSR-instruction
// writes straight through. An ecall runs a microsequence that saves mepc and mcause,
// rewrites mstatus and redirects fetch to mtvec. An mret runs one that rewrites
// mstatus and redirects fetch to mepc.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   trap_req/trap_cause/trap_pc        ecall request, cause and pc (sampled with trap_ack)
//   mret_req                           mret request
//   inst_csr_wen/waddr/wdata           CSR-instruction write request
//   csr_rdata                          combinational CSR read data at csr_raddr
//   trap_ack, mret_ack                 one-cycle accept pulses
//   inst_csr_ready                     CSR-instruction write committed this cycle
//   csr_wen/waddr/wdata, csr_raddr     CSR file port
//   redirect_valid, redirect_pc        one-cycle fetch redirect
//   stall                              hold the pipeline while busy or requesting
//
// state     | meaning
// IDLE      | passthrough of CSR-instruction writes, sample trap/mret requests
// T_EPC     | write mepc with captured pc
// T_CAUSE   | write mcause with captured cause
// T_STATUS  | write mstatus: MPIE=MIE, MIE=0, MPP=M
// T_VEC     | redirect to mtvec (direct mode), no write
// R_STATUS  | write mstatus: MIE=MPIE, MPIE=1, MPP=M
// R_EPC     | redirect to mepc, no write
module ysyx_23060191_trap_ctrl
    import ysyx_23060191_trap_ctrl_pkg::*;
#(
    parameter int XLEN = CPU_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_req,
    input  logic            inst_csr_wen,
    input  logic [11:0]     inst_csr_waddr,
    input  logic [XLEN-1:0] inst_csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            trap_ack,
    output logic            mret_ack,
    output logic            inst_csr_ready,
    output logic            csr_wen,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic [11:0]     csr_raddr,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            stall
);

    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        r[MSTATUS_MPIE] = v[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        r[MSTATUS_MIE]  = v[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [XLEN-1:0] cap_cause;
    logic [XLEN-1:0] cap_pc;
    logic            cap_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cap_cause <= '0;
            cap_pc    <= '0;
        end else begin
            state <= state_nxt;
            if (cap_en) begin
                cap_cause <= trap_cause;
                cap_pc    <= trap_pc;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cap_en         = 1'b0;
        trap_ack       = 1'b0;
        mret_ack       = 1'b0;
        inst_csr_ready = 1'b0;
        csr_wen        = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        csr_raddr      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = (state != ST_IDLE) | trap_req | mret_req;

        case (state)
            ST_IDLE: begin
                if (trap_req) begin
                    trap_ack  = 1'b1;
                    cap_en    = 1'b1;
                    state_nxt = ST_T_EPC;
                end else if (mret_req) begin
                    mret_ack  = 1'b1;
                    state_nxt = ST_R_STATUS;
                end else begin
                    inst_csr_ready = 1'b1;
                    csr_wen        = inst_csr_wen;
                    csr_waddr      = inst_csr_waddr;
                    csr_wdata      = inst_csr_wdata;
                end
            end
            ST_T_EPC: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = cap_pc;
                state_nxt = ST_T_CAUSE;
            end
            ST_T_CAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = cap_cause;
                state_nxt = ST_T_STATUS;
            end
            ST_T_STATUS: begin
                csr_raddr = CSR_MSTATUS;
                csr_wen   = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = mstatus_on_trap(csr_rdata);
                state_nxt = ST_T_VEC;
            end
            ST_T_VEC: begin
                // Direct mode only: the low two mode bits never reach the target.
                csr_raddr      = CSR_MTVEC;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
                state_nxt      = ST_IDLE;
            end
            ST_R_STATUS: begin
                csr_raddr = CSR_MSTATUS;
                csr_wen   = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = mstatus_on_mret(csr_rdata);
                state_nxt = ST_R_EPC;
            end
            ST_R_EPC: begin
                csr_raddr      = CSR_MEPC;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // While reset is asserted every output must read 0, including the
        // combinational passthrough and the request-driven stall.
        if (!rst_n) begin
            cap_en         = 1'b0;
            trap_ack       = 1'b0;
            mret_ack       = 1'b0;
            inst_csr_ready = 1'b0;
            csr_wen        = 1'b0;
            csr_waddr      = '0;
            csr_wdata      = '0;
            csr_raddr      = '0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            stall          = 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_trap_ctrl.sv
module tb_ysyx_23060191_trap_ctrl;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_req, mret_req, inst_csr_wen;
    logic [31:0] trap_cause, trap_pc, inst_csr_wdata, csr_rdata;
    logic [11:0] inst_csr_waddr;
    logic        trap_ack, mret_ack, inst_csr_ready, csr_wen, redirect_valid, stall;
    logic [11:0] csr_waddr, csr_raddr;
    logic [31:0] csr_wdata, redirect_pc;

    always #5 clk = ~clk;

    ysyx_23060191_trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_req(mret_req),
        .inst_csr_wen(inst_csr_wen), .inst_csr_waddr(inst_csr_waddr), .inst_csr_wdata(inst_csr_wdata),
        .csr_rdata(csr_rdata),
        .trap_ack(trap_ack), .mret_ack(mret_ack), .inst_csr_ready(inst_csr_ready),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_raddr(csr_raddr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall)
    );

    // CSR file contents as the architecture says they should be.
    logic [31:0] mcsr [4096];
    assign csr_rdata = mcsr[csr_raddr];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] enter_status(input logic [31:0] v);
        return (v & ~32'h0000_1888) | 32'h0000_1800 | ((v & 32'h8) << 4);
    endfunction

    function automatic logic [31:0] exit_status(input logic [31:0] v);
        return (v & ~32'h0000_1888) | 32'h0000_1880 | ((v & 32'h80) >> 4);
    endfunction

    // Model: which sequence is running (0 none, 1 trap, 2 mret) and how many
    // cycles into it we are.
    int          kind = 0;
    int          step = 0;
    logic [31:0] m_cause, m_pc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind = 0;
            step = 0;
        end else begin
            cyc++;
            if (kind == 0) begin
                if (trap_req) begin
                    kind = 1; step = 1; m_cause = trap_cause; m_pc = trap_pc;
                end else if (mret_req) begin
                    kind = 2; step = 1;
                end else if (inst_csr_wen) begin
                    mcsr[inst_csr_waddr] = inst_csr_wdata;
                end
            end else if (kind == 1) begin
                case (step)
                    1: mcsr[A_MEPC]    = m_pc;
                    2: mcsr[A_MCAUSE]  = m_cause;
                    3: mcsr[A_MSTATUS] = enter_status(mcsr[A_MSTATUS]);
                    default: ;
                endcase
                if (step == 4) kind = 0;
                step++;
            end else begin
                if (step == 1) mcsr[A_MSTATUS] = exit_status(mcsr[A_MSTATUS]);
                if (step == 2) kind = 0;
                step++;
            end
        end
    end

    // Per-cycle compare of every meaningful output against the model.
    always @(negedge clk) begin
        logic        e_ta, e_ma, e_rdy, e_wen, e_rv, e_stall, chk_r;
        logic [11:0] e_wa, e_ra;
        logic [31:0] e_wd, e_rpc;
        e_ta = 0; e_ma = 0; e_rdy = 0; e_wen = 0; e_rv = 0; e_stall = 0; chk_r = 0;
        e_wa = '0; e_ra = '0; e_wd = '0; e_rpc = '0;
        if (rst_n) begin
            e_stall = (kind != 0) || trap_req || mret_req;
            if (kind == 0) begin
                if (trap_req) e_ta = 1;
                else if (mret_req) e_ma = 1;
                else begin
                    e_rdy = 1; e_wen = inst_csr_wen; e_wa = inst_csr_waddr; e_wd = inst_csr_wdata;
                end
            end else if (kind == 1) begin
                case (step)
                    1: begin e_wen = 1; e_wa = A_MEPC;   e_wd = m_pc; end
                    2: begin e_wen = 1; e_wa = A_MCAUSE; e_wd = m_cause; end
                    3: begin e_wen = 1; e_wa = A_MSTATUS; e_wd = enter_status(mcsr[A_MSTATUS]);
                             chk_r = 1; e_ra = A_MSTATUS; end
                    default: begin e_rv = 1; e_rpc = mcsr[A_MTVEC] & ~32'h3;
                             chk_r = 1; e_ra = A_MTVEC; end
                endcase
            end else begin
                if (step == 1) begin
                    e_wen = 1; e_wa = A_MSTATUS; e_wd = exit_status(mcsr[A_MSTATUS]);
                    chk_r = 1; e_ra = A_MSTATUS;
                end else begin
                    e_rv = 1; e_rpc = mcsr[A_MEPC]; chk_r = 1; e_ra = A_MEPC;
                end
            end
        end
        chk("trap_ack", {31'd0, trap_ack}, {31'd0, e_ta});
        chk("mret_ack", {31'd0, mret_ack}, {31'd0, e_ma});
        chk("inst_csr_ready", {31'd0, inst_csr_ready}, {31'd0, e_rdy});
        chk("csr_wen", {31'd0, csr_wen}, {31'd0, e_wen});
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_rv});
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        if (e_wen || !rst_n) begin
            chk("csr_waddr", {20'd0, csr_waddr}, {20'd0, e_wa});
            chk("csr_wdata", csr_wdata, e_wd);
        end
        if (e_rv || !rst_n) chk("redirect_pc", redirect_pc, e_rpc);
        if (chk_r || !rst_n) chk("csr_raddr", {20'd0, csr_raddr}, {20'd0, e_ra});
    end

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic at_pos();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        trap_req = 0; mret_req = 0; inst_csr_wen = 0;
        trap_cause = '0; trap_pc = '0; inst_csr_waddr = '0; inst_csr_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mcsr[i] = '0;
        rst_n = 0;
        clear_inputs();

        // 1) reset with random inputs: everything zero
        for (int i = 0; i < 4; i++) begin
            trap_req = 1'($urandom); mret_req = 1'($urandom); inst_csr_wen = 1'($urandom);
            trap_cause = $urandom; trap_pc = $urandom;
            inst_csr_waddr = 12'($urandom); inst_csr_wdata = $urandom;
            at_neg();
            chk("rst_stall", {31'd0, stall}, 32'd0);
        end
        clear_inputs();
        at_pos();
        rst_n = 1;
        inst_csr_wen = 1; inst_csr_waddr = 12'h340; inst_csr_wdata = 32'h1234_5678;
        at_neg();
        chk("pass_wen", {31'd0, csr_wen}, 32'd1);
        chk("pass_addr", {20'd0, csr_waddr}, 32'h340);
        at_pos();
        clear_inputs();

        // 2) trap sequence
        mcsr[A_MSTATUS] = 32'h0000_1808;
        mcsr[A_MTVEC]   = 32'h8000_0101;
        trap_req = 1; trap_cause = 32'd11; trap_pc = 32'h8000_0010;
        at_neg();
        chk("t2_ack", {31'd0, trap_ack}, 32'd1);
        at_pos();
        clear_inputs();
        at_neg();
        chk("t2_mepc_addr", {20'd0, csr_waddr}, 32'h341);
        chk("t2_mepc", csr_wdata, 32'h8000_0010);
        at_neg();
        chk("t2_mcause", csr_wdata, 32'd11);
        at_neg();
        chk("t2_mstatus", csr_wdata, 32'h0000_1880);
        at_neg();
        chk("t2_redir_v", {31'd0, redirect_valid}, 32'd1);
        chk("t2_redir_pc", redirect_pc, 32'h8000_0100);
        at_neg();
        chk("t2_idle_stall", {31'd0, stall}, 32'd0);

        // 3) mret sequence
        at_pos();
        mcsr[A_MEPC] = 32'h8000_0014;
        mret_req = 1;
        at_neg();
        chk("t3_ack", {31'd0, mret_ack}, 32'd1);
        at_pos();
        mret_req = 0;
        at_neg();
        chk("t3_mstatus", csr_wdata, 32'h0000_1888);
        at_neg();
        chk("t3_redir_pc", redirect_pc, 32'h8000_0014);

        // 4) all requests together: trap wins, mret follows the trap redirect
        at_pos();
        trap_req = 1; mret_req = 1; trap_cause = 32'd8; trap_pc = 32'h8000_0040;
        inst_csr_wen = 1; inst_csr_waddr = A_MTVEC; inst_csr_wdata = 32'hFFFF_FFFF;
        at_neg();
        chk("t4_trap_ack", {31'd0, trap_ack}, 32'd1);
        chk("t4_mret_ack", {31'd0, mret_ack}, 32'd0);
        chk("t4_ready", {31'd0, inst_csr_ready}, 32'd0);
        at_pos();
        trap_req = 0;
        for (int i = 0; i < 4; i++) at_neg();
        chk("t4_redir_pc", redirect_pc, 32'h8000_0100);
        at_neg();
        chk("t4_mret_after", {31'd0, mret_ack}, 32'd1);
        at_pos();
        mret_req = 0;
        at_neg();
        at_neg();
        chk("t4_mret_pc", redirect_pc, 32'h8000_0040);
        at_neg();
        chk("t4_late_write", {31'd0, inst_csr_ready}, 32'd1);
        at_pos();
        clear_inputs();

        // 5) reset during T_CAUSE
        trap_req = 1; trap_cause = 32'd5; trap_pc = 32'h8000_0200;
        at_pos();
        trap_req = 0;
        at_pos();
        rst_n = 0;
        at_neg();
        chk("t5_rst_wen", {31'd0, csr_wen}, 32'd0);
        at_pos();
        rst_n = 1;
        at_neg();
        chk("t5_idle_stall", {31'd0, stall}, 32'd0);
        chk("t5_no_redir", {31'd0, redirect_valid}, 32'd0);
        at_pos();

        // 6) plain instruction write
        inst_csr_wen = 1; inst_csr_waddr = A_MEPC; inst_csr_wdata = 32'hDEAD_BEEF;
        at_neg();
        chk("t6_wen", {31'd0, csr_wen}, 32'd1);
        chk("t6_addr", {20'd0, csr_waddr}, 32'h341);
        chk("t6_data", csr_wdata, 32'hDEAD_BEEF);
        chk("t6_ready", {31'd0, inst_csr_ready}, 32'd1);
        chk("t6_stall", {31'd0, stall}, 32'd0);
        at_pos();
        clear_inputs();
        at_neg();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
